// File: rtl/mem_cfg_pkg.sv
// Shared memory-port types and helpers for the interleaved_memory requester path.
// Holds the access-width encoding, the default memory size and the initiator FSM states.
package mem_cfg_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_width_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } init_state_t;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int MEM_BYTES      = 2**DEFAULT_ADDR_W;

  // The unused encoding 2'd3 is treated as a full word so it can never slip past the bound check
  function automatic logic [2:0] width_bytes(input mem_width_t width);
    case (width)
      BYTE:    width_bytes = 3'd1;
      HALF:    width_bytes = 3'd2;
      default: width_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_bound_check.sv
// Combinational range check: an access is legal only if its last byte lies inside the memory.
module mem_bound_check
  import mem_cfg_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] addr,
  input  mem_width_t        width,
  output logic              in_range
);

  localparam logic [ADDR_W:0] LIMIT = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0] end_addr;

  // One extra bit keeps addr + bytes from wrapping near the top of memory
  assign end_addr = {1'b0, addr} + {{(ADDR_W-2){1'b0}}, width_bytes(width)};
  assign in_range = (end_addr <= LIMIT);

endmodule

// File: rtl/mem_access_initiator.sv
// Requester side of the interleaved_memory port: one outstanding load/store at a time,
// registered memory-side signals, and exactly one response per accepted request.
module mem_access_initiator
  import mem_cfg_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  mem_width_t        req_width_i,
  input  logic              req_sext_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output mem_width_t        mem_width_o,
  output logic              mem_sext_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  init_state_t state, state_next;
  logic        in_range;
  logic        accept;

  mem_bound_check #(.ADDR_W(ADDR_W)) u_bound_check (
    .addr     (req_addr_i),
    .width    (req_width_i),
    .in_range (in_range)
  );

  assign req_ready_o = (state == IDLE);
  assign accept      = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Out-of-range requests skip the memory entirely and go straight to the response
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = in_range ? ISSUE : RESP;
      ISSUE:   state_next = mem_we_o ? RESP : WAIT;
      WAIT:    state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // mem_we_o defaults low each cycle, so a store drives it only during its ISSUE cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_sext_o  <= 1'b0;
      mem_width_o <= BYTE;
    end else begin
      mem_we_o    <= 1'b0;
      rsp_valid_o <= (state_next == RESP);
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= !in_range;
            if (in_range) begin
              mem_we_o    <= req_we_i;
              mem_addr_o  <= req_addr_i;
              mem_width_o <= req_width_i;
              mem_sext_o  <= req_sext_i;
              mem_wdata_o <= req_wdata_i;
            end
          end
        end
        WAIT:    rsp_rdata_o <= mem_rdata_i;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed bench for mem_access_initiator driving a behavioural little-endian byte memory
// with a registered one-cycle read path.
module tb_mem_access_initiator;
  import mem_cfg_pkg::*;

  logic        clk;
  logic        rst_i;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  mem_width_t  req_width;
  logic        req_sext;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  mem_width_t  mem_width;
  logic        mem_sext;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [7:0]  mem_bytes [MEM_BYTES];
  int          test_count = 0;
  int          fail_count = 0;

  mem_access_initiator #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_width_i (req_width),
    .req_sext_i  (req_sext),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .mem_width_o (mem_width),
    .mem_sext_o  (mem_sext),
    .mem_addr_o  (mem_addr),
    .mem_we_o    (mem_we),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nbytes(input mem_width_t w);
    return (w == BYTE) ? 1 : ((w == HALF) ? 2 : 4);
  endfunction

  function automatic logic [31:0] modelRead(input logic [9:0] a, input mem_width_t w, input logic s);
    logic [31:0] v;
    int n;
    v = '0;
    n = nbytes(w);
    for (int i = 0; i < n; i++) v[8*i +: 8] = mem_bytes[(int'(a) + i) % MEM_BYTES];
    if (s && n == 1 && v[7])  v[31:8]  = '1;
    if (s && n == 2 && v[15]) v[31:16] = '1;
    return v;
  endfunction

  // Memory model: write commits at the edge ending the we cycle, read data is registered
  always @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < nbytes(mem_width); i++)
        mem_bytes[(int'(mem_addr) + i) % MEM_BYTES] <= mem_wdata[8*i +: 8];
    mem_rdata <= modelRead(mem_addr, mem_width, mem_sext);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Runs one request with rsp_ready high; latency counts edges from the accept edge to rsp_valid
  task automatic applyStimulus(input string tag, input logic we, input mem_width_t width,
                               input logic sext, input logic [9:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int lat;
    int we_cycles;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_width = width;
    req_sext  = sext;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = 1'b1;
    checkOutput({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat       = 1;
    we_cycles = mem_we ? 1 : 0;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (mem_we) we_cycles++;
    end
    checkOutput({tag, "_latency"}, lat, exp_lat);
    checkOutput({tag, "_rdata"}, rsp_rdata, exp_rdata);
    checkOutput({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    checkOutput({tag, "_we_cycles"}, we_cycles, (we && !exp_err) ? 1 : 0);
    if (!exp_err) checkOutput({tag, "_addr_hold"}, {22'b0, mem_addr}, {22'b0, addr});
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_rsp_drop"}, {31'b0, rsp_valid}, 32'd0);
    checkOutput({tag, "_idle"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem_bytes[i] = 8'h00;
    rst_i     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_width = BYTE;
    req_sext  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;

    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_mem_width", {30'b0, mem_width}, {30'b0, BYTE});
    checkOutput("rst_mem_sext", {31'b0, mem_sext}, 32'd0);

    applyStimulus("st_b0",    1'b1, BYTE, 1'b0, 10'd0,    32'h0000_00A7, 32'h0, 1'b0, 2);
    applyStimulus("st_w4",    1'b1, WORD, 1'b0, 10'd4,    32'h0DEF_ACED, 32'h0, 1'b0, 2);
    applyStimulus("ld_w4",    1'b0, WORD, 1'b0, 10'd4,    32'h0, 32'h0DEF_ACED, 1'b0, 3);
    applyStimulus("ld_w3",    1'b0, WORD, 1'b0, 10'd3,    32'h0, 32'hEFAC_ED00, 1'b0, 3);
    applyStimulus("ld_w1",    1'b0, WORD, 1'b0, 10'd1,    32'h0, 32'hED00_0000, 1'b0, 3);
    applyStimulus("st_b2",    1'b1, BYTE, 1'b0, 10'd2,    32'h0000_0013, 32'h0, 1'b0, 2);
    applyStimulus("ld_w1b",   1'b0, WORD, 1'b0, 10'd1,    32'h0, 32'hED00_1300, 1'b0, 3);
    applyStimulus("ld_b4s",   1'b0, BYTE, 1'b1, 10'd4,    32'h0, 32'hFFFF_FFED, 1'b0, 3);
    applyStimulus("ld_b7s",   1'b0, BYTE, 1'b1, 10'd7,    32'h0, 32'h0000_000D, 1'b0, 3);
    applyStimulus("ld_h4s",   1'b0, HALF, 1'b1, 10'd4,    32'h0, 32'hFFFF_ACED, 1'b0, 3);
    applyStimulus("ld_w1021", 1'b0, WORD, 1'b0, 10'd1021, 32'h0, 32'h0, 1'b1, 1);
    applyStimulus("st_w1021", 1'b1, WORD, 1'b0, 10'd1021, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
    applyStimulus("ld_w1020", 1'b0, WORD, 1'b0, 10'd1020, 32'h0, 32'h0, 1'b0, 3);
    applyStimulus("ld_b1023", 1'b0, BYTE, 1'b0, 10'd1023, 32'h0, 32'h0, 1'b0, 3);

    // Backpressure: response held while a competing store request is offered and must be ignored
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_width = WORD;
    req_sext  = 1'b0;
    req_addr  = 10'd4;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_we    = 1'b1;
    req_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("bp_rdata", rsp_rdata, 32'h0DEF_ACED);
      checkOutput("bp_req_ready", {31'b0, req_ready}, 32'd0);
      checkOutput("bp_mem_we", {31'b0, mem_we}, 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_rsp_drop", {31'b0, rsp_valid}, 32'd0);
    applyStimulus("ld_w4_after_bp", 1'b0, WORD, 1'b0, 10'd4, 32'h0, 32'h0DEF_ACED, 1'b0, 3);

    // Reset during the WAIT cycle of a load aborts it without a response
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_width = WORD;
    req_addr  = 10'd4;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    checkOutput("rstw_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rstw_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rstw_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    checkOutput("rstw_rsp_valid2", {31'b0, rsp_valid}, 32'd0);
    applyStimulus("ld_w4_after_rst", 1'b0, WORD, 1'b0, 10'd4, 32'h0, 32'h0DEF_ACED, 1'b0, 3);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
